// File: rtl/asreg_pkg.sv
// Shared types for the add/sub datapath command sequencer: opcodes,
// FSM states and the buffered command record.
package asreg_pkg;

    localparam int CMD_WIDTH = 16;
    localparam int CMD_TAGW  = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_COMMIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [2:0]           op;
        logic [CMD_WIDTH-1:0] a;
        logic [CMD_WIDTH-1:0] b;
        logic [CMD_TAGW-1:0]  tag;
    } cmd_t;

endpackage

// File: rtl/asreg_seq_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so the pointers
// wrap naturally. Count runs 0..DEPTH inclusive.
module cmd_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  entry_t                   din_i,
    output entry_t                   dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == AW'(0) + (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/asreg_seq.sv
// Command sequencer for the add/sub register datapath: buffers commands and
// walks each through the write1/2 -> write3 -> write4 -> done strobe sequence.
module asreg_seq
    import asreg_pkg::*;
#(
    parameter int WIDTH = CMD_WIDTH,
    parameter int DEPTH = 4,
    parameter int TAGW  = CMD_TAGW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [TAGW-1:0]  cmd_tag,
    output logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] in2,
    output logic             write1,
    output logic             write2,
    output logic             write3,
    output logic             write4,
    output logic [2:0]       ctrl,
    output logic             done,
    output logic [TAGW-1:0]  done_tag,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t          state_q;
    cmd_t            cmd_q;
    cmd_t            head;
    cmd_t            new_cmd;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;

    logic            write1_q;
    logic            write2_q;
    logic            write3_q;
    logic            write4_q;
    logic [2:0]      ctrl_q;
    logic            done_q;
    logic [TAGW-1:0] done_tag_q;
    logic            busy_q;

    assign new_cmd = '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
    assign push    = cmd_valid && cmd_ready;
    assign pop     = ((state_q == S_IDLE) || (state_q == S_DONE)) && !empty;

    // Occupancy after this edge; decides whether busy survives a return to IDLE.
    assign count_nxt = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

    cmd_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (cmd_t)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (new_cmd),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            write1_q   <= 1'b0;
            write2_q   <= 1'b0;
            write3_q   <= 1'b0;
            write4_q   <= 1'b0;
            ctrl_q     <= '0;
            done_q     <= 1'b0;
            done_tag_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            write1_q   <= 1'b0;
            write2_q   <= 1'b0;
            write3_q   <= 1'b0;
            write4_q   <= 1'b0;
            ctrl_q     <= '0;
            done_q     <= 1'b0;
            done_tag_q <= '0;
            busy_q     <= 1'b1;
            // Outputs are set for the state being entered, so they stay registered.
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (!empty) begin
                        cmd_q    <= head;
                        state_q  <= S_LOAD;
                        write1_q <= 1'b1;
                        write2_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= (count_nxt != '0);
                    end
                end
                S_LOAD: begin
                    state_q  <= S_EXEC;
                    ctrl_q   <= cmd_q.op;
                    write3_q <= 1'b1;
                end
                S_EXEC: begin
                    state_q  <= S_COMMIT;
                    ctrl_q   <= cmd_q.op;
                    write4_q <= 1'b1;
                end
                S_COMMIT: begin
                    state_q    <= S_DONE;
                    done_q     <= 1'b1;
                    done_tag_q <= cmd_q.tag;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= (count_nxt != '0);
                end
            endcase
        end
    end

    assign cmd_ready = !full;
    assign in1       = cmd_q.a;
    assign in2       = cmd_q.b;
    assign write1    = write1_q;
    assign write2    = write2_q;
    assign write3    = write3_q;
    assign write4    = write4_q;
    assign ctrl      = ctrl_q;
    assign done      = done_q;
    assign done_tag  = done_tag_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_asreg_seq.sv
// Scoreboard bench for asreg_seq with a behavioural model of the add/sub
// datapath hanging off the strobe interface.
module tb_asreg_seq;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [3:0]  cmd_tag;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        write1;
    logic        write2;
    logic        write3;
    logic        write4;
    logic [2:0]  ctrl;
    logic        done;
    logic [3:0]  done_tag;
    logic        busy;

    asreg_seq #(.WIDTH(16), .DEPTH(DEPTH), .TAGW(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_tag   (cmd_tag),
        .in1       (in1),
        .in2       (in2),
        .write1    (write1),
        .write2    (write2),
        .write3    (write3),
        .write4    (write4),
        .ctrl      (ctrl),
        .done      (done),
        .done_tag  (done_tag),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Datapath model: operand regs and out4 on rising edge, result on falling edge.
    logic [15:0] dp_r1, dp_r2, dp_res, dp_out4;
    always @(posedge clock) begin
        if (write1) dp_r1 <= in1;
        if (write2) dp_r2 <= in2;
        if (write4) dp_out4 <= dp_res;
    end
    always @(negedge clock) begin
        if (write3) dp_res <= (ctrl == 3'b001) ? dp_r1 - dp_r2 : dp_r1 + dp_r2;
    end

    // Reference: each accepted command finishes 4 edges after the later of its
    // accept edge and the previous command's done edge.
    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  tag;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   last_done = 0;
    bit   mon_en    = 0;
    bit   saw_full  = 0;
    int   prev_occ  = 0;

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            sb.delete();
            last_done = 0;
        end else if (cmd_valid && cmd_ready) begin
            exp_t e;
            e.op  = cmd_op;
            e.a   = cmd_a;
            e.b   = cmd_b;
            e.res = (cmd_op == 3'b001) ? cmd_a - cmd_b : cmd_a + cmd_b;
            e.tag = cmd_tag;
            e.done_cyc = ((cyc > last_done) ? cyc : last_done) + 4;
            last_done  = e.done_cyc;
            sb.push_back(e);
        end
    end

    always @(negedge clock) begin
        if (mon_en) begin
            int         occ;
            logic [6:0] exp_strb;
            logic       exp_done;
            occ = 0;
            foreach (sb[i]) if (sb[i].done_cyc - 3 > cyc) occ++;
            if (occ == DEPTH) chk("cmd_ready_full", cmd_ready, 1'b0);
            else if (prev_occ != DEPTH) chk("cmd_ready", cmd_ready, 1'b1);
            prev_occ = occ;
            if (!cmd_ready) saw_full = 1;
            chk("busy", busy, sb.size() != 0);

            exp_strb = '0;
            exp_done = 1'b0;
            if (sb.size() != 0) begin
                if (cyc == sb[0].done_cyc - 3) begin
                    exp_strb = 7'b1100000;
                    chk("operands", {in1, in2}, {sb[0].a, sb[0].b});
                end
                if (cyc == sb[0].done_cyc - 2) exp_strb = {4'b0010, sb[0].op};
                if (cyc == sb[0].done_cyc - 1) exp_strb = {4'b0001, sb[0].op};
                exp_done = (cyc == sb[0].done_cyc);
            end
            chk("strobes_ctrl", {write1, write2, write3, write4, ctrl}, exp_strb);
            chk("done", done, exp_done);
            if (done && exp_done) begin
                chk("done_tag", done_tag, sb[0].tag);
                chk("out4", dp_out4, sb[0].res);
                void'(sb.pop_front());
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tag);
        bit rdy;
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        n = 0;
        do begin
            @(negedge clock);
            rdy = cmd_ready;
            @(posedge clock);
            n++;
        end while (!rdy && n < 200);
        if (!rdy) chk("accept_timeout", 1'b0, 1'b1);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clock);
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_tag   = '0;
        reset     = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", {in1, in2, write1, write2, write3, write4, ctrl, done, done_tag, busy},
            '0);
        chk("reset_ready", cmd_ready, 1'b1);
        reset  = 1'b0;
        mon_en = 1;

        // Directed ADD and SUB.
        send(3'b000, 16'h0005, 16'h0003, 4'd1);
        wait_idle();
        chk("add_result", dp_out4, 16'h0008);
        send(3'b001, 16'h0003, 16'h0005, 4'd2);
        wait_idle();
        chk("sub_result", dp_out4, 16'hFFFE);

        // Back-to-back burst forcing backpressure.
        saw_full = 0;
        for (int i = 0; i < 6; i++) send(3'b000, 16'(i * 3), 16'(100 + i), 4'(i));
        wait_idle();
        chk("backpressure_seen", saw_full, 1'b1);

        // Reset during EXEC aborts the command.
        send(3'b000, 16'h1234, 16'h0001, 4'd7);
        begin
            int n;
            n = 0;
            while (!write3 && n < 50) begin
                @(negedge clock);
                n++;
            end
            chk("exec_reached", write3, 1'b1);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_outputs", {write1, write2, write3, write4, busy, done}, '0);
        chk("abort_ready", cmd_ready, 1'b1);
        reset = 1'b0;
        repeat (8) @(posedge clock);
        send(3'b001, 16'h0100, 16'h0001, 4'd9);
        wait_idle();
        chk("post_abort_result", dp_out4, 16'h00FF);

        // Randomized stream with gaps; monitor checks every cycle.
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
            send(3'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 4'(i));
        end
        wait_idle();

        // Quiet period: monitor expects no strobes and busy low.
        repeat (20) @(posedge clock);
        #1;
        chk("idle_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/asreg_seq.md
# asreg_seq

Command sequencer that drives the add/sub register datapath (two operand registers, add/sub unit, falling-edge result register, rising-edge output register). It accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO. For each command it issues the `write1..write4` strobe sequence and holds `ctrl`, then pulses `done` with the command tag once `out4` holds the result. It is the initiating side of the datapath's strobe interface and sits between the instruction front end and the datapath.

## Interface
- `WIDTH`, 16: operand width; matches datapath `in1`/`in2`.
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TAGW`, 4: command tag width.

- `clock`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: FIFO not full; registered.
- `cmd_op`  in  3: opcode, forwarded verbatim to `ctrl`.
- `cmd_a`, `cmd_b`  in  WIDTH: operands.
- `cmd_tag`  in  TAGW: returned on `done_tag`.
- `in1`, `in2`  out  WIDTH: operand buses to datapath.
- `write1`, `write2`, `write3`, `write4`  out  1: datapath register load strobes.
- `ctrl`  out  3: add/sub function select.
- `done`  out  1: one-cycle pulse; `out4` valid.
- `done_tag`  out  TAGW: tag of completed command; valid with `done`.
- `busy`  out  1: FSM not IDLE or FIFO non-empty.

## Operation
- Push on a rising edge with `cmd_valid && cmd_ready`; entry is {op, a, b, tag}.
- FSM states: IDLE, LOAD, EXEC, COMMIT, DONE.
  - IDLE: if FIFO non-empty, pop the head into working registers and go to LOAD; otherwise stay.
  - LOAD: `in1`=a, `in2`=b, `write1`=`write2`=1. Go to EXEC.
  - EXEC: `ctrl`=op, `write3`=1. The result register captures on the falling edge inside this cycle. Go to COMMIT.
  - COMMIT: `ctrl`=op held, `write4`=1. Go to DONE.
  - DONE: `done`=1, `done_tag`=tag. If FIFO non-empty, pop and go to LOAD (back-to-back); else go to IDLE.
- Outside their active state, strobes are 0 and `ctrl`=0. `in1`/`in2` always show the working registers.
- No FIFO bypass: a command pushed into an empty FIFO is popped on the following edge.
- Simultaneous push and pop: count is unchanged and both pointers advance. Push is impossible when full because `cmd_ready`=0.
- Pointers wrap modulo DEPTH. Count is tracked to DEPTH inclusive.
- Reset (any state, mid-command included) on the next edge:
  - FIFO emptied.
  - FSM → IDLE.
  - All outputs 0, except `cmd_ready`=1.
  - The partial command is discarded and no `done` is produced.

## Timing
- Reset values: `cmd_ready`=1; all other outputs 0.
- Accept edge E0 → LOAD during cycle after E1 → EXEC after E2 → COMMIT after E3 → DONE after E4.
- `done` is high in the cycle after E4. Latency from accept to `done` is 4 cycles when the sequencer is idle.
- Throughput: one command per 4 cycles sustained (DONE overlaps the next pop).
- All outputs are registered; no combinational path from `cmd_*` to any output.
- `cmd_ready` reflects count after the previous edge. It may read 0 for one cycle after a pop from full.

## Structure
- Shared package `asreg_pkg`:
  - opcode constants `OP_ADD`=3'b000, `OP_SUB`=3'b001;
  - FSM state enum;
  - command struct {op, a, b, tag}.
- One sub-module: `cmd_fifo`, a synchronous DEPTH-entry FIFO with push/pop/full/empty/count, same `clock`/`reset`.

## Test plan
- Single ADD, a=0x0005, b=0x0003, tag=1:
  - strobe order is `write1`+`write2`, then `write3`, then `write4`;
  - `ctrl`=000 during EXEC and COMMIT;
  - `done` with `done_tag`=1 four cycles after accept; datapath `out4`=0x0008.
- SUB, a=0x0003, b=0x0005 → `out4`=0xFFFE, `ctrl`=001 held for 2 cycles.
- Push 5 commands back-to-back with DEPTH=4:
  - `cmd_ready` drops after the 4th is buffered;
  - all 5 complete in order, `done` spaced exactly 4 cycles apart;
  - tags 0..4 in order.
- Push while popping with FIFO at DEPTH-1: count stays constant and no entry is lost or duplicated across pointer wrap.
- Assert `reset` during EXEC:
  - next cycle all strobes 0, `busy`=0, `cmd_ready`=1;
  - no `done` for the aborted tag;
  - a fresh command afterwards completes normally.
- Idle with `cmd_valid`=0 for 20 cycles: no strobes and `busy`=0 throughout.
